// File: rtl/wb_ic_pkg.sv
// Shared types, limits and packed-vector slice helpers for the Wishbone data interconnect.
// No logic state; the helpers are purely combinational bit selects.
// No handshake of its own; it is only imported by the interconnect and its decoder.
package wb_ic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        DECERR = 2'd2
    } ic_state_e;

    localparam int MAX_SLAVES = 16;
    localparam int MAX_ADR_W  = 64;
    localparam int MAX_DAT_W  = 128;
    localparam int ADR_VEC_W  = MAX_SLAVES * MAX_ADR_W;
    localparam int DAT_VEC_W  = MAX_SLAVES * MAX_DAT_W;

    function automatic logic [MAX_ADR_W-1:0] adr_slice(input logic [ADR_VEC_W-1:0] vec,
                                                       input int idx, input int w);
        logic [MAX_ADR_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_ADR_W; b++) begin
            if (b < w) r[b] = vec[idx*w + b];
        end
        return r;
    endfunction

    function automatic logic [MAX_ADR_W-1:0] slv_base(input logic [ADR_VEC_W-1:0] vec,
                                                      input int idx, input int w);
        return adr_slice(vec, idx, w);
    endfunction

    function automatic logic [MAX_ADR_W-1:0] slv_mask(input logic [ADR_VEC_W-1:0] vec,
                                                      input int idx, input int w);
        return adr_slice(vec, idx, w);
    endfunction

    function automatic logic [MAX_DAT_W-1:0] slv_dat(input logic [DAT_VEC_W-1:0] vec,
                                                     input int idx, input int w);
        logic [MAX_DAT_W-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_DAT_W; b++) begin
            if (b < w) r[b] = vec[idx*w + b];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Address decoder: mask/base compare per slave, lowest matching index wins, miss when none match.
// Latency: zero cycles, purely combinational.
// Backpressure: none; stall handling lives in the interconnect.
module wb_addr_decoder
    import wb_ic_pkg::*;
#(
    parameter int                          NUM_SLAVES = 4,
    parameter int                          ADR_W      = 32,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLV_MASK   = '0
) (
    input  logic [ADR_W-1:0]      adr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  miss
);

    logic found;

    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found &&
                ((adr & ADR_W'(slv_mask(ADR_VEC_W'(SLV_MASK), i, ADR_W))) ==
                 ADR_W'(slv_base(ADR_VEC_W'(SLV_BASE), i, ADR_W)))) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = !found;
    end

endmodule

// File: rtl/wb_data_interconnect.sv
// Single-master, N-slave pipelined Wishbone interconnect, one transaction in flight; optional watchdog via WB_IC_TIMEOUT_EN.
// Latency: request and response paths are zero-cycle; a new request is taken the cycle after the previous ack/err.
// Backpressure: master stall mirrors the decoded slave's stall in IDLE and is held high while a response is pending.
module wb_data_interconnect
    import wb_ic_pkg::*;
#(
    parameter int                          NUM_SLAVES     = 4,
    parameter int                          ADR_W          = 32,
    parameter int                          DAT_W          = 32,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLV_BASE       = '0,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLV_MASK       = '0,
    parameter int                          TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        m_wb_cyc_i,
    input  logic                        m_wb_stb_i,
    input  logic                        m_wb_we_i,
    input  logic [ADR_W-1:0]            m_wb_adr_i,
    input  logic [DAT_W-1:0]            m_wb_dat_i,
    input  logic [DAT_W/8-1:0]          m_wb_sel_i,
    output logic                        m_wb_stall_o,
    output logic                        m_wb_ack_o,
    output logic                        m_wb_err_o,
    output logic [DAT_W-1:0]            m_wb_dat_o,
    output logic [NUM_SLAVES-1:0]       s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]       s_wb_stb_o,
    output logic                        s_wb_we_o,
    output logic [ADR_W-1:0]            s_wb_adr_o,
    output logic [DAT_W-1:0]            s_wb_dat_o,
    output logic [DAT_W/8-1:0]          s_wb_sel_o,
    input  logic [NUM_SLAVES-1:0]       s_wb_stall_i,
    input  logic [NUM_SLAVES-1:0]       s_wb_ack_i,
    input  logic [NUM_SLAVES-1:0]       s_wb_err_i,
    input  logic [NUM_SLAVES*DAT_W-1:0] s_wb_dat_i,
    output logic                        busy_o
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES || ADR_W > MAX_ADR_W || DAT_W > MAX_DAT_W ||
        (DAT_W % 8) != 0 || TIMEOUT_CYCLES < 8 || TIMEOUT_CYCLES > 65535) begin : g_param_err
        $error("wb_data_interconnect: illegal parameter set");
    end

    ic_state_e             state;
    logic [NUM_SLAVES-1:0] owner;
    logic [NUM_SLAVES-1:0] hit;
    logic                  miss;
    logic                  req;
    logic                  accept;
    logic                  own_ack;
    logic                  own_err;
    logic                  timeout;
    logic [DAT_W-1:0]      own_dat;

    wb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADR_W      (ADR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .adr  (m_wb_adr_i),
        .hit  (hit),
        .miss (miss)
    );

    assign req     = m_wb_cyc_i & m_wb_stb_i;
    assign own_ack = |(owner & s_wb_ack_i);
    assign own_err = |(owner & s_wb_err_i);

    assign s_wb_we_o  = m_wb_we_i;
    assign s_wb_adr_o = m_wb_adr_i;
    assign s_wb_dat_o = m_wb_dat_i;
    assign s_wb_sel_o = m_wb_sel_i;
    assign busy_o     = (state != IDLE);

`ifdef WB_IC_TIMEOUT_EN
    logic [15:0] wait_cnt;
    // An owner response in the limit cycle takes precedence over the watchdog.
    assign timeout = m_wb_cyc_i && (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) && !own_ack && !own_err;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        own_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (owner[i]) own_dat = own_dat | DAT_W'(slv_dat(DAT_VEC_W'(s_wb_dat_i), i, DAT_W));
        end
    end

    always_comb begin
        s_wb_cyc_o   = '0;
        s_wb_stb_o   = '0;
        m_wb_stall_o = 1'b0;
        m_wb_ack_o   = 1'b0;
        m_wb_err_o   = 1'b0;
        m_wb_dat_o   = '0;
        accept       = 1'b0;
        if (reset_i) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (miss) begin
                            accept = 1'b1;
                        end else begin
                            s_wb_cyc_o   = hit;
                            s_wb_stb_o   = hit;
                            m_wb_stall_o = |(hit & s_wb_stall_i);
                            accept       = !(|(hit & s_wb_stall_i));
                        end
                    end
                end
                WAIT: begin
                    m_wb_stall_o = 1'b1;
                    // With cyc low the master has abandoned the cycle: nothing is forwarded.
                    if (m_wb_cyc_i) begin
                        m_wb_err_o = own_err | timeout;
                        m_wb_ack_o = own_ack & !own_err;
                        m_wb_dat_o = (own_ack & !own_err) ? own_dat : '0;
                        s_wb_cyc_o = timeout ? '0 : owner;
                    end
                end
                DECERR: begin
                    m_wb_stall_o = 1'b1;
                    m_wb_err_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
            owner <= '0;
`ifdef WB_IC_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (miss) begin
                            state <= DECERR;
                        end else begin
                            state <= WAIT;
                            owner <= hit;
`ifdef WB_IC_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
`ifdef WB_IC_TIMEOUT_EN
                    wait_cnt <= wait_cnt + 16'd1;
`endif
                    if (!m_wb_cyc_i || own_ack || own_err || timeout) begin
                        state <= IDLE;
                        owner <= '0;
                    end
                end
                DECERR: state <= IDLE;
                default: begin
                    state <= IDLE;
                    owner <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_data_interconnect.sv
// Directed bench for wb_data_interconnect: table of single transactions plus hand-written stall, abort, watchdog and reset sequences.
module tb_wb_data_interconnect;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [NS*AW-1:0] BASE = {32'h4000_0000, 32'h0000_8000, 32'h0000_0100, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_8000};

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             m_wb_cyc_i, m_wb_stb_i, m_wb_we_i;
    logic [AW-1:0]    m_wb_adr_i;
    logic [DW-1:0]    m_wb_dat_i;
    logic [DW/8-1:0]  m_wb_sel_i;
    logic             m_wb_stall_o, m_wb_ack_o, m_wb_err_o;
    logic [DW-1:0]    m_wb_dat_o;
    logic [NS-1:0]    s_wb_cyc_o, s_wb_stb_o;
    logic             s_wb_we_o;
    logic [AW-1:0]    s_wb_adr_o;
    logic [DW-1:0]    s_wb_dat_o;
    logic [DW/8-1:0]  s_wb_sel_o;
    logic [NS-1:0]    s_wb_stall_i, s_wb_ack_i, s_wb_err_i;
    logic [NS*DW-1:0] s_wb_dat_i;
    logic             busy_o;

    wb_data_interconnect #(
        .NUM_SLAVES     (NS),
        .ADR_W          (AW),
        .DAT_W          (DW),
        .SLV_BASE       (BASE),
        .SLV_MASK       (MASK),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .m_wb_cyc_i   (m_wb_cyc_i),
        .m_wb_stb_i   (m_wb_stb_i),
        .m_wb_we_i    (m_wb_we_i),
        .m_wb_adr_i   (m_wb_adr_i),
        .m_wb_dat_i   (m_wb_dat_i),
        .m_wb_sel_i   (m_wb_sel_i),
        .m_wb_stall_o (m_wb_stall_o),
        .m_wb_ack_o   (m_wb_ack_o),
        .m_wb_err_o   (m_wb_err_o),
        .m_wb_dat_o   (m_wb_dat_o),
        .s_wb_cyc_o   (s_wb_cyc_o),
        .s_wb_stb_o   (s_wb_stb_o),
        .s_wb_we_o    (s_wb_we_o),
        .s_wb_adr_o   (s_wb_adr_o),
        .s_wb_dat_o   (s_wb_dat_o),
        .s_wb_sel_o   (s_wb_sel_o),
        .s_wb_stall_i (s_wb_stall_i),
        .s_wb_ack_i   (s_wb_ack_i),
        .s_wb_err_i   (s_wb_err_i),
        .s_wb_dat_i   (s_wb_dat_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int applied     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_slaves();
        s_wb_ack_i = '0;
        s_wb_err_i = '0;
        s_wb_dat_i = '0;
    endtask

    task automatic start_req(input logic [31:0] adr);
        m_wb_adr_i = adr;
        m_wb_cyc_i = 1'b1;
        m_wb_stb_i = 1'b1;
    endtask

    typedef struct {
        logic [31:0] adr;
        int          rsp_slv;    // responding slave, -1 for none
        logic        rsp_ack;
        logic        rsp_err;
        logic [31:0] rsp_dat;
        int          noise_slv;  // non-owner slave pulsing ack+err, -1 for none
        logic [3:0]  exp_stb;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_8004, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, -1, 4'b0100, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0100, 0, 1'b1, 1'b0, 32'h1234_5678,  1, 4'b0001, 1'b1, 1'b0, 32'h1234_5678};
        vecs[2] = '{32'hF000_0000, -1, 1'b0, 1'b0, 32'h0,          0, 4'b0000, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{32'h4000_0010, 3, 1'b0, 1'b1, 32'h7777_7777, -1, 4'b1000, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{32'h0000_7FFC, 0, 1'b1, 1'b1, 32'h55AA_55AA, -1, 4'b0001, 1'b0, 1'b1, 32'h0};
        vecs[5] = '{32'h0000_8010, -1, 1'b0, 1'b0, 32'h0,         -1, 4'b0000, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{32'h0000_800F, 2, 1'b1, 1'b0, 32'hCAFE_F00D,  3, 4'b0100, 1'b1, 1'b0, 32'hCAFE_F00D};
        vecs[7] = '{32'h0000_01FF, 0, 1'b1, 1'b0, 32'h0BAD_CAFE,  1, 4'b0001, 1'b1, 1'b0, 32'h0BAD_CAFE};

        reset_i      = 1'b0;
        m_wb_we_i    = 1'b1;
        m_wb_dat_i   = 32'hA5A5_0F0F;
        m_wb_sel_i   = 4'hC;
        s_wb_stall_i = '0;
        s_wb_ack_i   = '1;
        s_wb_err_i   = '1;
        s_wb_dat_i   = '1;
        start_req(32'h0000_8004);
        #2;
        check("rst_s_cyc", 32'(s_wb_cyc_o), 32'h0);
        check("rst_s_stb", 32'(s_wb_stb_o), 32'h0);
        check("rst_stall", 32'(m_wb_stall_o), 32'h0);
        check("rst_ack", 32'(m_wb_ack_o), 32'h0);
        check("rst_err", 32'(m_wb_err_o), 32'h0);
        check("rst_dat", m_wb_dat_o, 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_bcast_adr", s_wb_adr_o, 32'h0000_8004);
        check("rst_bcast_dat", s_wb_dat_o, 32'hA5A5_0F0F);
        check("rst_bcast_sel", 32'(s_wb_sel_o), 32'hC);
        check("rst_bcast_we", 32'(s_wb_we_o), 32'h1);
        @(negedge clk_i);
        @(negedge clk_i);
        m_wb_cyc_i = 1'b0;
        m_wb_stb_i = 1'b0;
        clear_slaves();
        reset_i = 1'b1;

        for (int v = 0; v < 8; v++) begin
            @(negedge clk_i);
            start_req(vecs[v].adr);
            m_wb_we_i = (v % 2 == 1);
            #1;
            check("req_stb", 32'(s_wb_stb_o), 32'(vecs[v].exp_stb));
            check("req_stall", 32'(m_wb_stall_o), 32'h0);
            @(posedge clk_i);
            @(negedge clk_i);
            m_wb_stb_i = 1'b0;
            if (vecs[v].noise_slv >= 0) begin
                s_wb_ack_i[vecs[v].noise_slv]           = 1'b1;
                s_wb_err_i[vecs[v].noise_slv]           = 1'b1;
                s_wb_dat_i[vecs[v].noise_slv*DW +: DW] = 32'hBAD0_BAD0;
            end
            if (vecs[v].rsp_slv >= 0) begin
                s_wb_ack_i[vecs[v].rsp_slv]           = vecs[v].rsp_ack;
                s_wb_err_i[vecs[v].rsp_slv]           = vecs[v].rsp_err;
                s_wb_dat_i[vecs[v].rsp_slv*DW +: DW] = vecs[v].rsp_dat;
            end
            #1;
            check("rsp_ack", 32'(m_wb_ack_o), 32'(vecs[v].exp_ack));
            check("rsp_err", 32'(m_wb_err_o), 32'(vecs[v].exp_err));
            check("rsp_dat", m_wb_dat_o, vecs[v].exp_dat);
            check("rsp_s_cyc", 32'(s_wb_cyc_o), 32'(vecs[v].exp_stb));
            check("rsp_s_stb", 32'(s_wb_stb_o), 32'h0);
            check("rsp_stall", 32'(m_wb_stall_o), 32'h1);
            check("rsp_busy", 32'(busy_o), 32'h1);
            @(posedge clk_i);
            @(negedge clk_i);
            clear_slaves();
            #1;
            check("post_busy", 32'(busy_o), 32'h0);
            check("post_err", 32'(m_wb_err_o), 32'h0);
            m_wb_cyc_i = 1'b0;
        end

        // Slave stalls three cycles before taking the request.
        @(negedge clk_i);
        s_wb_stall_i[2] = 1'b1;
        start_req(32'h0000_8004);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_hold", 32'(m_wb_stall_o), 32'h1);
            check("stall_stb", 32'(s_wb_stb_o), 32'h4);
            check("stall_busy", 32'(busy_o), 32'h0);
            @(negedge clk_i);
        end
        s_wb_stall_i[2] = 1'b0;
        #1;
        check("stall_release", 32'(m_wb_stall_o), 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        m_wb_stb_i = 1'b0;
        #1;
        check("stall_wait", 32'(busy_o), 32'h1);
        s_wb_ack_i[2]      = 1'b1;
        s_wb_dat_i[64 +: 32] = 32'h0000_0042;
        #1;
        check("stall_ack_dat", m_wb_dat_o, 32'h0000_0042);
        @(negedge clk_i);
        clear_slaves();
        m_wb_cyc_i = 1'b0;

        // Master abort followed by a late ack from the former owner.
        @(negedge clk_i);
        start_req(32'h0000_8004);
        @(posedge clk_i);
        @(negedge clk_i);
        m_wb_cyc_i = 1'b0;
        m_wb_stb_i = 1'b0;
        #1;
        check("abort_s_cyc", 32'(s_wb_cyc_o), 32'h0);
        check("abort_ack", 32'(m_wb_ack_o), 32'h0);
        @(negedge clk_i);
        s_wb_ack_i[2]        = 1'b1;
        s_wb_dat_i[64 +: 32] = 32'hFEED_FACE;
        #1;
        check("late_ack", 32'(m_wb_ack_o), 32'h0);
        check("late_dat", m_wb_dat_o, 32'h0);
        check("late_busy", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        clear_slaves();

`ifdef WB_IC_TIMEOUT_EN
        begin
            int first_err = 0;
            @(negedge clk_i);
            start_req(32'h0000_8004);
            @(posedge clk_i);
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk_i);
                m_wb_stb_i = 1'b0;
                #1;
                if (m_wb_err_o && first_err == 0) first_err = k;
            end
            check("timeout_cycle", 32'(first_err), 32'd8);
            check("timeout_busy", 32'(busy_o), 32'h0);
            m_wb_cyc_i = 1'b0;

            @(negedge clk_i);
            start_req(32'h0000_8004);
            @(posedge clk_i);
            for (int k = 1; k < 8; k++) begin
                @(negedge clk_i);
                m_wb_stb_i = 1'b0;
            end
            @(negedge clk_i);
            s_wb_ack_i[2] = 1'b1;
            #1;
            check("ack_vs_timeout_ack", 32'(m_wb_ack_o), 32'h1);
            check("ack_vs_timeout_err", 32'(m_wb_err_o), 32'h0);
            @(negedge clk_i);
            clear_slaves();
            m_wb_cyc_i = 1'b0;
        end
`else
        begin
            int err_seen = 0;
            @(negedge clk_i);
            start_req(32'h0000_8004);
            @(posedge clk_i);
            for (int k = 1; k <= 120; k++) begin
                @(negedge clk_i);
                m_wb_stb_i = 1'b0;
                #1;
                if (m_wb_err_o) err_seen++;
            end
            check("silent_busy", 32'(busy_o), 32'h1);
            check("silent_no_err", 32'(err_seen), 32'h0);
            m_wb_cyc_i = 1'b0;
            @(negedge clk_i);
            #1;
            check("silent_abort_busy", 32'(busy_o), 32'h0);
        end
`endif

        // Reset asserted while waiting on a slave.
        @(negedge clk_i);
        start_req(32'h4000_0000);
        @(posedge clk_i);
        @(negedge clk_i);
        m_wb_stb_i = 1'b0;
        #1;
        check("midrst_pre_cyc", 32'(s_wb_cyc_o), 32'h8);
        reset_i = 1'b0;
        #1;
        check("midrst_s_cyc", 32'(s_wb_cyc_o), 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        reset_i    = 1'b1;
        m_wb_cyc_i = 1'b0;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
